sync_fifo_lvl: RTL and testbench
================================

Name: sync_fifo_lvl

Overview:
Parametrised synchronous FIFO for AXI command/data channels. It replaces the fixed power-of-two command FIFO and adds:
- arbitrary (non-power-of-2) depth
- a live occupancy count
- registered almost-full and almost-empty thresholds
- a synchronous flush
- an optional registered output stage

It sits between AXI masters/slaves and internal datapaths wherever a buffer needs level-based flow control.

Parameters:
DATA_W, 32, payload width in bits.
DEPTH, 4, storage entries; any integer >= 2.
CNT_W, 3, count width; must be >= clog2(DEPTH+2).
AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.
OUT_REG, 1, 1 = registered output stage (adds one entry of capacity); 0 = combinational read from storage.

Ports:
clk  in  1  clock; all logic on the rising edge.
resetn  in  1  synchronous, active-low reset.
flush  in  1  synchronous discard of all contents.
s_valid  in  1  write request.
s_ready  out  1  FIFO can accept data.
s_data  in  DATA_W  write payload.
m_valid  out  1  read data available.
m_ready  in  1  consumer accepts data.
m_data  out  DATA_W  read payload.
count  out  CNT_W  entries held (storage plus output register); max DEPTH+OUT_REG.
almost_full  out  1  registered level flag.
almost_empty  out  1  registered level flag.
peak_clr  in  1  clears peak (used only with the optional feature).
peak  out  CNT_W  high-watermark of count.

Behaviour:
Reset:
- Reset is resetn, synchronous, active-low; clock is clk.
- While resetn=0: wptr=rptr=0, count=0, m_valid=0, s_ready=0, almost_full=0, almost_empty=1, peak=0, m_data=0 (OUT_REG=1).
- Storage array is not reset.
- First cycle after release: s_ready=1.

Handshake:
- Push occurs on s_valid&s_ready; pop occurs on m_valid&m_ready.
- m_valid and m_data must not depend combinationally on m_ready.
- s_ready = (count < DEPTH+OUT_REG) & ~flush.

Pointers:
- wptr and rptr are clog2(DEPTH) bits. Each wraps from DEPTH-1 to 0 explicitly; no power-of-2 aliasing.
- Full/empty are decided from count, not from pointer compare.

OUT_REG=0:
- m_data = mem[rptr]; m_valid = (count != 0) & ~flush.
- Write-to-m_valid latency is 1 cycle; no same-cycle bypass.

OUT_REG=1:
- The output register loads from storage whenever it is empty, or is being popped while storage is non-empty.
- Write-to-m_valid latency from empty is 1 cycle: storage is bypassed when both storage and the output register are empty.
- m_valid = out_valid & ~flush.
- Sustained throughput is 1 item/cycle.

Count:
- count_next = count + push - pop.
- Push and pop in the same cycle leave count unchanged.

Full:
- When count = DEPTH+OUT_REG, s_ready=0 even if a pop occurs that cycle; there is no ready pass-through.
- The freed slot is visible the next cycle.

Empty:
- Push plus m_ready in the same cycle produces no pop; data appears next cycle.

Flags:
- almost_full and almost_empty are registered from count_next, so they change in the same cycle count changes.

Flush:
- Flush has priority over push and pop.
- During the flush cycle: s_ready=0 and m_valid=0, so no handshake occurs.
- Next cycle: pointers=0, count=0, out_valid=0, almost_empty=1, almost_full=0.
- Flush held for multiple cycles keeps the FIFO empty.
- resetn has priority over flush.

Reset mid-operation:
- All contents are discarded exactly as at power-up.
- In-flight handshakes in the reset cycle are ignored.

Optional Feature:
SYNC_FIFO_LVL_PEAK_EN:
- Defined: peak is a register. It updates to count_next when count_next > peak.
- peak clears to 0 on resetn=0, flush, or peak_clr.
- When peak_clr coincides with a push, peak takes count_next.
- Not defined: peak is tied to 0, peak_clr is ignored, and no peak register is synthesised.

Test Plan:
1. DEPTH=4, OUT_REG=1, m_ready=0; push 0x11..0x55 -> five accepts, count=5, s_ready=0 on the 6th; almost_full=1 from count=3; almost_empty=0 from count=2.
2. DEPTH=5 (non-pow2), OUT_REG=0; continuously push an incrementing value with m_ready=1 for 20 cycles -> output sequence in order, no loss or duplication across wrap at index 4; count steady at 1.
3. Full FIFO, assert m_ready and s_valid in the same cycle -> one pop, no push; s_ready=1 the next cycle; count = DEPTH+OUT_REG-1.
4. Three entries held; assert flush for 1 cycle together with s_valid=1 and m_ready=1 -> no handshake that cycle; next cycle count=0, m_valid=0, almost_empty=1; a subsequent push of 0xA5 emerges first.
5. Drop resetn for 1 cycle with the FIFO half full -> all outputs at reset values; first data out after reset is the first post-reset push.
6. With SYNC_FIFO_LVL_PEAK_EN: fill to 4, drain to 0 -> peak=4; pulse peak_clr -> peak=0; push 1 -> peak=1. Without the macro -> peak=0 throughout.

Source files
------------

// File: rtl/sync_fifo_lvl_if.sv
// Handshake bundle for sync_fifo_lvl: a write channel (s_*) into the FIFO
// and a read channel (m_*) out of it. The FIFO uses the slave modport; the
// producer/consumer environment uses the master modport.
interface sync_fifo_lvl_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with arbitrary depth, live occupancy count, registered
// almost-full/almost-empty flags, synchronous flush and an optional output
// register stage (OUT_REG). Define SYNC_FIFO_LVL_PEAK_EN to build the
// high-watermark (peak) register; otherwise peak is tied to zero.
module sync_fifo_lvl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 3,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  parameter int OUT_REG  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  sync_fifo_lvl_if.slave   bus,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic             peak_clr,
  output logic [CNT_W-1:0] peak
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(DEPTH + OUT_REG);
  localparam logic [CNT_W-1:0] AF_L = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_L = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic [CNT_W-1:0]  count_next;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No ready pass-through when full: a freed slot shows up next cycle.
  assign bus.s_ready = resetn & ~flush & (count < CAP);
  assign push        = bus.s_valid & bus.s_ready;
  assign pop         = bus.m_valid & bus.m_ready;
  assign count_next  = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);

  // Occupancy and level flags, registered from count_next so they move with count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      almost_full  <= (count_next >= AF_L);
      almost_empty <= (count_next <= AE_L);
    end
  end

  // Storage array write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= bus.s_data;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              out_vld_p1;
      logic [DATA_W-1:0] out_data_p1;
      logic [CNT_W-1:0]  st_cnt;
      logic              out_take;
      logic              bypass;

      assign st_cnt   = count - CNT_W'(out_vld_p1);
      assign out_take = ~out_vld_p1 | pop;
      // With storage empty and the output stage free, a push goes straight
      // to the output stage, giving one-cycle latency and full throughput.
      assign bypass   = out_take & (st_cnt == '0);
      assign wr_en    = push & ~bypass;

      assign bus.m_valid = resetn & ~flush & out_vld_p1;
      assign bus.m_data  = out_data_p1;

      // Pointer and output-stage update: refill from storage or bypass.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          wptr        <= '0;
          rptr        <= '0;
          out_vld_p1  <= 1'b0;
          out_data_p1 <= '0;
        end else if (flush) begin
          wptr       <= '0;
          rptr       <= '0;
          out_vld_p1 <= 1'b0;
        end else begin
          if (out_take) begin
            if (st_cnt != '0) begin
              out_data_p1 <= mem[rptr];
              out_vld_p1  <= 1'b1;
              rptr        <= ptr_inc(rptr);
            end else if (push) begin
              out_data_p1 <= bus.s_data;
              out_vld_p1  <= 1'b1;
            end else begin
              out_vld_p1 <= 1'b0;
            end
          end
          if (wr_en) wptr <= ptr_inc(wptr);
        end
      end
    end else begin : g_no_out_reg
      assign wr_en       = push;
      assign bus.m_valid = resetn & ~flush & (count != '0);
      assign bus.m_data  = mem[rptr];

      // Pointer update: write on push, advance read on pop.
      always_ff @(posedge clk) begin
        if (!resetn || flush) begin
          wptr <= '0;
          rptr <= '0;
        end else begin
          if (push) wptr <= ptr_inc(wptr);
          if (pop)  rptr <= ptr_inc(rptr);
        end
      end
    end
  endgenerate

`ifdef SYNC_FIFO_LVL_PEAK_EN
  // High-watermark of count; a clear coinciding with a push keeps the new level.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= push ? count_next : '0;
    end else if (count_next > peak) begin
      peak <= count_next;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak            = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: instance A (DEPTH=4, OUT_REG=1) covers
// fill/full/flush/reset/peak; instance B (DEPTH=5, OUT_REG=0) covers
// streaming across pointer wrap.
module tb_sync_fifo_lvl;
  logic       clk = 1'b0;
  logic       resetn;
  logic       flush_a, flush_b;
  logic       peak_clr_a, peak_clr_b;
  logic [2:0] count_a, count_b, peak_a, peak_b;
  logic       af_a, ae_a, af_b, ae_b;
  int         checks = 0;
  int         errors = 0;

  sync_fifo_lvl_if #(.DATA_W(32)) ifa ();
  sync_fifo_lvl_if #(.DATA_W(32)) ifb ();

  sync_fifo_lvl #(.DATA_W(32), .DEPTH(4), .CNT_W(3), .AF_LEVEL(3), .AE_LEVEL(1), .OUT_REG(1)) u_a (
    .clk(clk), .resetn(resetn), .flush(flush_a), .bus(ifa),
    .count(count_a), .almost_full(af_a), .almost_empty(ae_a),
    .peak_clr(peak_clr_a), .peak(peak_a)
  );

  sync_fifo_lvl #(.DATA_W(32), .DEPTH(5), .CNT_W(3), .AF_LEVEL(3), .AE_LEVEL(1), .OUT_REG(0)) u_b (
    .clk(clk), .resetn(resetn), .flush(flush_b), .bus(ifb),
    .count(count_b), .almost_full(af_b), .almost_empty(ae_b),
    .peak_clr(peak_clr_b), .peak(peak_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [31:0] v);
`ifdef SYNC_FIFO_LVL_PEAK_EN
    return v;
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial begin
    resetn = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    peak_clr_a = 1'b0; peak_clr_b = 1'b0;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.m_ready = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.m_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_count", count_a, 0);
    chk("rst_m_valid", ifa.m_valid, 0);
    chk("rst_s_ready", ifa.s_ready, 0);
    chk("rst_af", af_a, 0);
    chk("rst_ae", ae_a, 1);
    chk("rst_m_data", ifa.m_data, 0);
    chk("rst_peak", peak_a, 0);
    chk("rst_count_b", count_b, 0);
    resetn = 1'b1;
    tick();
    chk("post_rst_s_ready", ifa.s_ready, 1);

    // Fill A with 0x11..0x55, no pops
    for (int i = 0; i < 5; i++) begin
      ifa.s_valid = 1'b1; ifa.s_data = 32'h11 * (i + 1);
      #1 chk("fill_s_ready", ifa.s_ready, 1);
      tick();
      chk("fill_count", count_a, i + 1);
      chk("fill_af", af_a, (i + 1) >= 3);
      chk("fill_ae", ae_a, (i + 1) <= 1);
    end
    ifa.s_data = 32'h66;
    #1 chk("full_s_ready", ifa.s_ready, 0);
    tick();
    chk("full_count", count_a, 5);
    chk("full_m_valid", ifa.m_valid, 1);
    chk("full_m_data", ifa.m_data, 32'h11);

    // Full: pop and push requested together -> only the pop happens
    ifa.m_ready = 1'b1; ifa.s_data = 32'h77;
    #1 chk("full_pop_s_ready", ifa.s_ready, 0);
    tick();
    ifa.s_valid = 1'b0; ifa.m_ready = 1'b0;
    #1 chk("after_pop_count", count_a, 4);
    chk("after_pop_s_ready", ifa.s_ready, 1);
    chk("after_pop_m_data", ifa.m_data, 32'h22);

    // Pop one more to hold three entries
    ifa.m_ready = 1'b1;
    tick();
    ifa.m_ready = 1'b0;
    chk("three_count", count_a, 3);
    chk("three_m_data", ifa.m_data, 32'h33);

    // Flush with s_valid and m_ready asserted
    flush_a = 1'b1; ifa.s_valid = 1'b1; ifa.s_data = 32'h99; ifa.m_ready = 1'b1;
    #1 chk("flush_s_ready", ifa.s_ready, 0);
    chk("flush_m_valid", ifa.m_valid, 0);
    tick();
    flush_a = 1'b0; ifa.s_valid = 1'b0; ifa.m_ready = 1'b0;
    #1 chk("flush_count", count_a, 0);
    chk("flush_m_valid_after", ifa.m_valid, 0);
    chk("flush_ae", ae_a, 1);
    chk("flush_af", af_a, 0);
    ifa.s_valid = 1'b1; ifa.s_data = 32'hA5;
    tick();
    ifa.s_valid = 1'b0;
    chk("a5_m_valid", ifa.m_valid, 1);
    chk("a5_m_data", ifa.m_data, 32'hA5);
    chk("a5_count", count_a, 1);

    // Half full, then reset for one cycle with handshakes requested
    ifa.s_valid = 1'b1; ifa.s_data = 32'hC1;
    tick();
    ifa.s_data = 32'hC2;
    tick();
    chk("half_count", count_a, 3);
    resetn = 1'b0; ifa.s_data = 32'hC3; ifa.m_ready = 1'b1;
    #1 chk("inrst_s_ready", ifa.s_ready, 0);
    chk("inrst_m_valid", ifa.m_valid, 0);
    tick();
    resetn = 1'b1; ifa.s_valid = 1'b0; ifa.m_ready = 1'b0;
    chk("midrst_count", count_a, 0);
    chk("midrst_m_valid", ifa.m_valid, 0);
    chk("midrst_m_data", ifa.m_data, 0);
    chk("midrst_ae", ae_a, 1);
    chk("midrst_af", af_a, 0);
    chk("midrst_peak", peak_a, 0);
    ifa.s_valid = 1'b1; ifa.s_data = 32'hD4;
    tick();
    chk("d4_m_data", ifa.m_data, 32'hD4);

    // Peak: fill to 4, drain to 0
    for (int i = 0; i < 3; i++) begin
      ifa.s_data = 32'hE1 + i;
      tick();
    end
    ifa.s_valid = 1'b0;
    chk("peak_fill_count", count_a, 4);
    chk("peak_fill", peak_a, pk(4));
    ifa.m_ready = 1'b1;
    chk("drain0", ifa.m_data, 32'hD4);
    tick();
    chk("drain1", ifa.m_data, 32'hE1);
    tick();
    chk("drain2", ifa.m_data, 32'hE2);
    tick();
    chk("drain3", ifa.m_data, 32'hE3);
    tick();
    ifa.m_ready = 1'b0;
    chk("drain_count", count_a, 0);
    chk("drain_peak", peak_a, pk(4));
    peak_clr_a = 1'b1;
    tick();
    peak_clr_a = 1'b0;
    chk("peak_clr", peak_a, 0);
    ifa.s_valid = 1'b1; ifa.s_data = 32'hF0;
    tick();
    chk("peak_one", peak_a, pk(1));
    peak_clr_a = 1'b1; ifa.s_data = 32'hF1;
    tick();
    peak_clr_a = 1'b0; ifa.s_valid = 1'b0;
    chk("peak_clr_push", peak_a, pk(2));

    // Instance B: stream across pointer wrap at depth 5
    ifb.m_ready = 1'b1; ifb.s_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ifb.s_data = k;
      #1;
      if (k == 0) chk("b_m_valid0", ifb.m_valid, 0);
      else begin
        chk("b_m_valid", ifb.m_valid, 1);
        chk("b_m_data", ifb.m_data, k - 1);
      end
      tick();
      chk("b_count", count_b, 1);
    end
    ifb.s_valid = 1'b0;
    #1 chk("b_last", ifb.m_data, 19);
    tick();
    ifb.m_ready = 1'b0;
    chk("b_empty", count_b, 0);
    chk("b_m_valid_end", ifb.m_valid, 0);
    chk("b_peak", peak_b, pk(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
